// File: rtl/bfp_pkg.sv
// Shared types and helpers for the R2FFT block-floating-point width detector.
package bfp_pkg;

  typedef enum logic [1:0] {
    BFP_IDLE = 2'd0,
    BFP_ACC  = 2'd1,
    BFP_EVAL = 2'd2
  } bfp_det_state_t;

  localparam int BFP_FFT_N_DEF    = 10;
  localparam int BFP_PASS_LEN_DEF = 1 << BFP_FFT_N_DEF;

  // One's-complement magnitude of a sign-extended sample; callers truncate to W-1 bits.
  function automatic logic [31:0] bfp_mag1c(input logic [31:0] x);
    return x ^ {32{x[31]}};
  endfunction

endpackage

// File: rtl/bfp_lead_one.sv
// Priority encoder: index of the highest set bit plus one, zero for an all-zero input.
module bfp_lead_one #(
  parameter int IW = 16,
  parameter int OW = 5
) (
  input  logic [IW-1:0] din,
  output logic [OW-1:0] raw
);

  always_comb begin
    raw = '0;
    for (int i = 0; i < IW; i++) begin
      if (din[i]) begin
        raw = OW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/bfp_bitwidth_detect.sv
// Per-pass BFP width detector feeding the bit-width accumulator's init/update ports.
// Optional sticky clamp flag `ovf` is built when BFP_BWDET_OVF_EN is defined.
module bfp_bitwidth_detect
  import bfp_pkg::*;
#(
  parameter int FFT_DW    = 16,
  parameter int FFT_BFPDW = 5,
  parameter int FFT_N     = BFP_FFT_N_DEF,
  parameter int GROWTH    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        first,
  input  logic                        din_valid,
  input  logic signed [FFT_DW+GROWTH-1:0] din_re,
  input  logic signed [FFT_DW+GROWTH-1:0] din_im,
  output logic                        init,
  output logic [FFT_BFPDW-1:0]        bw_init,
  output logic                        update,
  output logic [FFT_BFPDW-1:0]        bw_new,
  output logic                        busy
`ifdef BFP_BWDET_OVF_EN
  ,
  output logic                        ovf
`endif
);

  localparam int W = FFT_DW + GROWTH;
  localparam logic [FFT_N-1:0] LAST_IDX = FFT_N'((1 << FFT_N) - 1);
  localparam logic [FFT_BFPDW-1:0] BW_MAX = FFT_BFPDW'(FFT_DW);

  bfp_det_state_t       r_state;
  logic [FFT_N-1:0]     r_cnt;
  logic [W-2:0]         r_acc;
  logic [W-2:0]         w_mag_re;
  logic [W-2:0]         w_mag_im;
  logic [FFT_BFPDW-1:0] w_raw;
  logic [FFT_BFPDW-1:0] w_bw;
  logic [FFT_BFPDW-1:0] r_bw;
  logic                 r_first;
  logic                 r_init;
  logic                 r_update;
  logic                 r_busy;
`ifdef BFP_BWDET_OVF_EN
  logic                 r_ovf;
`endif

  // The magnitude sign bit is always zero, so only W-1 bits are kept.
  assign w_mag_re = (W-1)'(bfp_mag1c(32'(din_re)));
  assign w_mag_im = (W-1)'(bfp_mag1c(32'(din_im)));

  bfp_lead_one #(
    .IW(W - 1),
    .OW(FFT_BFPDW)
  ) u_lead_one (
    .din(r_acc),
    .raw(w_raw)
  );

  assign w_bw = (w_raw > BW_MAX) ? BW_MAX : w_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BFP_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_bw     <= '0;
      r_first  <= 1'b0;
      r_init   <= 1'b0;
      r_update <= 1'b0;
      r_busy   <= 1'b0;
`ifdef BFP_BWDET_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_init   <= 1'b0;
      r_update <= 1'b0;
      // start wins over everything: aborts any pass, including one in EVAL.
      if (start) begin
        r_state <= BFP_ACC;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_first <= first;
        r_busy  <= 1'b1;
`ifdef BFP_BWDET_OVF_EN
        if (first) begin
          r_ovf <= 1'b0;
        end
`endif
      end else begin
        case (r_state)
          BFP_IDLE: begin
            r_busy <= 1'b0;
          end
          BFP_ACC: begin
            if (din_valid) begin
              r_acc <= r_acc | w_mag_re | w_mag_im;
              r_cnt <= r_cnt + FFT_N'(1);
              if (r_cnt == LAST_IDX) begin
                r_state <= BFP_EVAL;
              end
            end
          end
          BFP_EVAL: begin
            r_bw     <= w_bw;
            r_init   <= r_first;
            r_update <= ~r_first;
            r_busy   <= 1'b0;
            r_state  <= BFP_IDLE;
`ifdef BFP_BWDET_OVF_EN
            if (w_raw > BW_MAX) begin
              r_ovf <= 1'b1;
            end
`endif
          end
          default: begin
            r_state <= BFP_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign init    = r_init;
  assign update  = r_update;
  assign bw_init = r_bw;
  assign bw_new  = r_bw;
  assign busy    = r_busy;
`ifdef BFP_BWDET_OVF_EN
  assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_bfp_bitwidth_detect.sv
// Scoreboard bench for bfp_bitwidth_detect (FFT_N=3); a second GROWTH=2 instance covers clamping.
module tb_bfp_bitwidth_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, first, din_valid;
  logic signed [16:0] din_re, din_im;
  logic signed [17:0] din2_re, din2_im;
  logic init1, update1, busy1, init2, update2, busy2;
  logic [4:0] bw_init1, bw_new1, bw_init2, bw_new2;
`ifdef BFP_BWDET_OVF_EN
  logic ovf1, ovf2;
`endif

  bfp_bitwidth_detect #(.FFT_DW(16), .FFT_BFPDW(5), .FFT_N(3), .GROWTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .first(first), .din_valid(din_valid),
    .din_re(din_re), .din_im(din_im), .init(init1), .bw_init(bw_init1),
    .update(update1), .bw_new(bw_new1), .busy(busy1)
`ifdef BFP_BWDET_OVF_EN
    , .ovf(ovf1)
`endif
  );

  bfp_bitwidth_detect #(.FFT_DW(16), .FFT_BFPDW(5), .FFT_N(3), .GROWTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .first(first), .din_valid(din_valid),
    .din_re(din2_re), .din_im(din2_im), .init(init2), .bw_init(bw_init2),
    .update(update2), .bw_new(bw_new2), .busy(busy2)
`ifdef BFP_BWDET_OVF_EN
    , .ovf(ovf2)
`endif
  );

  typedef struct {
    bit is_init;
    int bw;
    int cyc;
    bit ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   exp_ovf2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor for the GROWTH=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && (init1 === 1'b1 || update1 === 1'b1)) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_pulse", {31'd0, init1 | update1}, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dut1_kind_init", {31'd0, init1}, {31'd0, e.is_init});
        chk("dut1_kind_update", {31'd0, update1}, {31'd0, ~e.is_init});
        chk("dut1_bw", {27'd0, (e.is_init ? bw_init1 : bw_new1)}, e.bw);
        chk("dut1_pulse_cycle", cyc, e.cyc);
        chk("dut1_busy_at_pulse", {31'd0, busy1}, 32'd0);
`ifdef BFP_BWDET_OVF_EN
        chk("dut1_ovf", {31'd0, ovf1}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Monitor for the GROWTH=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && (init2 === 1'b1 || update2 === 1'b1)) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_pulse", {31'd0, init2 | update2}, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("dut2_kind_init", {31'd0, init2}, {31'd0, e.is_init});
        chk("dut2_kind_update", {31'd0, update2}, {31'd0, ~e.is_init});
        chk("dut2_bw", {27'd0, (e.is_init ? bw_init2 : bw_new2)}, e.bw);
        chk("dut2_pulse_cycle", cyc, e.cyc);
`ifdef BFP_BWDET_OVF_EN
        chk("dut2_ovf", {31'd0, ovf2}, {31'd0, e.ovf});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input bit f);
    start = 1'b1;
    first = f;
    din_valid = 1'b1;
    din_re = 17'sh07FFF;
    din_im = 17'sh07FFF;
    din2_re = 18'sh07FFF;
    din2_im = 18'sh07FFF;
    if (f) exp_ovf2 = 1'b0;
    tick();
    start = 1'b0;
    din_valid = 1'b0;
    din_re = '0;
    din_im = '0;
    din2_re = '0;
    din2_im = '0;
  endtask

  task automatic send2(input logic signed [16:0] re, input logic signed [16:0] im,
                       input logic signed [17:0] re2, input logic signed [17:0] im2);
    din_valid = 1'b1;
    din_re = re;
    din_im = im;
    din2_re = re2;
    din2_im = im2;
    last_cyc = cyc;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send(input logic signed [16:0] re, input logic signed [16:0] im);
    send2(re, im, 18'(re), 18'(im));
  endtask

  task automatic send_n(input int n, input logic signed [16:0] re, input logic signed [16:0] im);
    for (int i = 0; i < n; i++) send(re, im);
  endtask

  task automatic push_exp(input bit f, input int bw1, input int bw2);
    exp_t e1;
    exp_t e2;
    e1 = '{is_init: f, bw: bw1, cyc: last_cyc + 2, ovf: 1'b0};
    e2 = '{is_init: f, bw: bw2, cyc: last_cyc + 2, ovf: exp_ovf2};
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_init"}, {31'd0, init1 | init2}, 32'd0);
    chk({tag, "_update"}, {31'd0, update1 | update2}, 32'd0);
    chk({tag, "_bw_init"}, {27'd0, bw_init1 | bw_init2}, 32'd0);
    chk({tag, "_bw_new"}, {27'd0, bw_new1 | bw_new2}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy1 | busy2}, 32'd0);
`ifdef BFP_BWDET_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf1 | ovf2}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; first = 1'b0; din_valid = 1'b0;
    din_re = '0; din_im = '0; din2_re = '0; din2_im = '0;
    idle(3);
    rst = 1'b0;
    chk_idle("reset");

    // All-zero input-load pass.
    do_start(1'b1);
    chk("busy_after_start", {31'd0, busy1}, 32'd1);
    send_n(8, 17'sd0, 17'sd0);
    push_exp(1'b1, 0, 0);
    idle(2);

    // Single significant sample, rest zero; -1 and 0 contribute nothing.
    do_start(1'b0);
    send(17'sh03000, 17'sd0);
    send(-17'sd1, 17'sd0);
    send_n(6, 17'sd0, -17'sd1);
    push_exp(1'b0, 14, 14);
    idle(2);

    do_start(1'b0);
    send(17'sd0, -17'sh04000);
    send_n(7, 17'sd0, 17'sd0);
    push_exp(1'b0, 14, 14);
    idle(2);

    do_start(1'b0);
    send_n(3, 17'sd0, 17'sd0);
    send(17'sh04000, 17'sd0);
    send_n(4, 17'sd0, 17'sd0);
    push_exp(1'b0, 15, 15);
    idle(2);

    do_start(1'b0);
    send_n(7, 17'sd0, 17'sd0);
    send(17'sd0, -17'sh04001);
    push_exp(1'b0, 15, 15);
    idle(2);

    // Full 17-bit positive magnitude reaches the nominal width exactly.
    do_start(1'b0);
    send(17'sh08000, 17'sd0);
    send_n(7, 17'sd0, 17'sd0);
    push_exp(1'b0, 16, 16);
    idle(2);

    // GROWTH=2 instance gets 0x10000: raw 17 clamps to 16 and sets ovf.
    do_start(1'b0);
    send2(17'sd1, 17'sd0, 18'sh10000, 18'sd0);
    send_n(7, 17'sd0, 17'sd0);
`ifdef BFP_BWDET_OVF_EN
    exp_ovf2 = 1'b1;
`endif
    push_exp(1'b0, 1, 16);
    idle(2);

    // Gapped samples, aborted after 5, then a full 0x0100 pass.
    do_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      send(17'sh07FFF, 17'sh07FFF);
      idle($urandom_range(0, 2));
    end
    do_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 2));
      send(17'sh00100, 17'sd0);
    end
    push_exp(1'b0, 9, 9);
    idle(3);

    // Reset during ACC.
    do_start(1'b0);
    send_n(3, 17'sh00FF0, 17'sd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ovf2 = 1'b0;
    chk_idle("rst_acc");

    // Reset during EVAL.
    do_start(1'b0);
    send_n(8, 17'sh00100, 17'sd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_eval");
    idle(3);

    // start during EVAL suppresses that pass; the restarted pass reports.
    do_start(1'b0);
    send_n(8, 17'sh07FFF, 17'sd0);
    do_start(1'b1);
    send_n(8, 17'sd1, 17'sd0);
    push_exp(1'b1, 1, 1);
    idle(3);

    // Back-to-back passes: second start lands in the first pass's pulse cycle.
    do_start(1'b0);
    send_n(8, 17'sh00010, 17'sd0);
    push_exp(1'b0, 5, 5);
    tick();
    do_start(1'b1);
    send_n(8, 17'sd0, -17'sh00200);
    push_exp(1'b1, 9, 9);
    idle(4);

    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfp_bitwidth_detect.md
# bfp_bitwidth_detect

Per-pass block-floating-point width detector for the R2FFT datapath; the producer side of the BFP bit-width accumulator interface. It observes the butterfly output samples of one FFT stage (or the input-load pass), OR-accumulates their one's-complement magnitudes, and at the end of the pass reports the significant bit width. The report is a one-cycle `init` pulse with `bw_init` (input-load pass) or an `update` pulse with `bw_new` (stage pass), wired directly to the accumulator's ports.

## Interface
- `FFT_DW`, 16: nominal data width; reported widths saturate at this value.
- `FFT_BFPDW`, 5: width of reported bit-width fields.
- `FFT_N`, 10: log2 of samples per pass (pass length 2^FFT_N).
- `GROWTH`, 1: extra bits on butterfly outputs; sample width is FFT_DW+GROWTH.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a pass: clear accumulator and counter, latch `first`.
- `first`  in  1  sampled with `start`; 1 = input-load pass (report via `init`), 0 = stage pass (report via `update`).
- `din_valid`  in  1  sample qualifier.
- `din_re`  in  FFT_DW+GROWTH  signed real part.
- `din_im`  in  FFT_DW+GROWTH  signed imaginary part.
- `init`  out  1  one-cycle pulse, input-load pass result.
- `bw_init`  out  FFT_BFPDW  width for `init`.
- `update`  out  1  one-cycle pulse, stage pass result.
- `bw_new`  out  FFT_BFPDW  width for `update`.
- `busy`  out  1  pass in progress (ACC or EVAL).

## Operation
- FSM states: IDLE, ACC, EVAL.
  - IDLE --start--> ACC.
  - ACC --accepted sample with cnt==2^FFT_N-1--> EVAL.
  - EVAL --> IDLE (unconditional, one cycle).
- Sample acceptance: `din_valid` while in ACC and `start` low. Samples in IDLE/EVAL are ignored. Each accepted sample increments `cnt` (FFT_N bits).
- Magnitude rule: m(x) = x XOR {W{x[MSB]}}, with W = FFT_DW+GROWTH. `acc <= acc | m(re) | m(im)`. `acc` is W-1 bits; the sign bit of m is always 0.
- Width rule: raw = index of highest set bit of `acc` + 1, or 0 if `acc`==0. Reported bw = min(raw, FFT_DW).
  - 0 and -1 contribute nothing.
  - +0x4000 and -0x4001 both give 15.
- In EVAL: bw is registered into a single result register that drives both `bw_init` and `bw_new`. `init` (if latched `first`=1) or `update` (if 0) is registered high for the next cycle.
- Only one of `init`/`update` is ever high. Exactly one pulse per completed pass.
- `start` in any state aborts the current pass with no pulse and restarts (acc=0, cnt=0, `first` re-latched). A sample in the same cycle as `start` is dropped.
- A `start` in EVAL suppresses that pass's pulse.
- Reset values: `init`=0, `update`=0, `bw_init`=`bw_new`=0, `busy`=0, state IDLE, acc=0, cnt=0. `rst` mid-pass discards the pass; no pulse.

## Timing
- Cycle S: `start` sampled. `busy`=1 from S+1.
- Cycle L: last sample accepted. acc updated and state=EVAL at L+1.
- L+1: EVAL. Pulse and bw registered at the L+2 edge, visible during cycle L+2. `busy`=0 from L+2.
- Latency from last sample to pulse: 2 cycles. `bw_*` is stable from the pulse cycle until the next pulse.
- Minimum pass: 2^FFT_N + 2 cycles. `start` is accepted in the pulse cycle (back-to-back passes).
- Gaps in `din_valid` are allowed; they only stretch ACC.

## Configuration
- `BFP_BWDET_OVF_EN`: when defined, adds output `ovf` (1 bit, reset 0).
  - `ovf` is a sticky flag set at the EVAL edge when raw > FFT_DW (clamp applied).
  - It clears only on `rst` or on a `start` with `first`=1.
- Without the macro: no `ovf` port, clamping is silent, identical otherwise.

## Structure
- Shared package `bfp_pkg`:
  - FSM state enum `bfp_det_state_t`.
  - Function `bfp_mag1c` (one's-complement magnitude).
  - Localparam for the pass length.
- One sub-module `bfp_lead_one`: parameterized priority encoder, W-1 bits in, FFT_BFPDW-wide raw index+1 out, 0 for all-zero. Purely combinational; its output feeds the registered clamp.

## Test plan
Bench parameters: FFT_DW=16, FFT_N=3, GROWTH=1.
- All-zero pass, `first`=1 → `init` pulse 2 cycles after 8th sample, `bw_init`=0, `update` stays 0.
- `first`=0, one sample re=0x3000, rest 0 → `update`, `bw_new`=14. Repeat with im=-0x4000 → 14. With re=0x4000 → 15.
- re=+0x8000 (17-bit) → `bw_new`=16. With GROWTH=2 and re=0x10000 → `bw_new`=16 clamped, `ovf`=1 when the macro is defined.
- Valid with random gaps, then `start` after 5 samples, then 8 samples of 0x0100 → exactly one `update`, `bw_new`=9; first-pass data excluded.
- `rst` asserted during ACC and again during EVAL → no pulse, all outputs 0, `busy`=0 next cycle.
- Back-to-back passes with `start` in the pulse cycle → two pulses 10 cycles apart, correct independent bw values.
